// File: rtl/snake_pkg.sv
// Shared constants, state encoding and addressing for the snake box probe.
// The shadow framebuffer is packed row-major, 160 pixels per row.
package snake_pkg;

  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int XDIM    = 10;
  localparam int YDIM    = 10;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int AW = 15;

  localparam int NPIX = XSCREEN * YSCREEN;

  localparam logic [CW-1:0] BG = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } probe_state_e;

  // y*160 + x without a multiplier
  function automatic logic [AW-1:0] pix_addr(
    input logic [XW-1:0] px,
    input logic [YW-1:0] py
  );
    logic [AW-1:0] yy;
    yy = {8'b0, py};
    return (yy << 7) + (yy << 5) + {7'b0, px};
  endfunction

endpackage

// File: rtl/shadow_fb.sv
// Private copy of the VGA framebuffer: one write port, one registered
// read port, read-before-write. Contents power up as zero (= BG).
module shadow_fb
  import snake_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] mem [0:NPIX-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/snake_box_probe.sv
// Snoops plot writes into a shadow framebuffer and scans an
// XDIM x YDIM box for any non-background or off-screen pixel.
module snake_box_probe #(
  parameter int XSCREEN = snake_pkg::XSCREEN,
  parameter int YSCREEN = snake_pkg::YSCREEN,
  parameter int XDIM    = snake_pkg::XDIM,
  parameter int YDIM    = snake_pkg::YDIM,
  parameter logic [2:0] BG = snake_pkg::BG
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       req,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] hit_colour,
  output logic       oob
);

  import snake_pkg::pix_addr;
  import snake_pkg::probe_state_e;
  import snake_pkg::IDLE;
  import snake_pkg::SCAN;
  import snake_pkg::DRAIN;
  import snake_pkg::DONE;

  localparam logic [8:0] XLIM  = 9'(XSCREEN);
  localparam logic [7:0] YLIM  = 8'(YSCREEN);
  localparam logic [7:0] XLAST = 8'(XDIM - 1);
  localparam logic [6:0] YLAST = 7'(YDIM - 1);

  probe_state_e state, state_n;

  logic [7:0]  ox, xc;
  logic [6:0]  oy, yc;
  logic [8:0]  col;
  logic [7:0]  row;
  logic        in_rng;
  logic        last;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic        ev_valid;
  logic        ev_in;

  assign wr_en = plot
    && ({1'b0, x} < XLIM)
    && ({1'b0, y} < YLIM);
  assign wr_addr = pix_addr(x, y);

  // Sums are one bit wider so origins near 255/127 never wrap to 0
  assign col    = {1'b0, ox} + {1'b0, xc};
  assign row    = {1'b0, oy} + {1'b0, yc};
  assign in_rng = (col < XLIM) && (row < YLIM);
  assign last   = (xc == XLAST) && (yc == YLAST);

  assign rd_addr = in_rng
    ? pix_addr(col[7:0], row[6:0])
    : '0;

  shadow_fb u_fb (
    .clk     (CLOCK_50),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (colour),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n = state;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (req)
          state_n = SCAN;
      end
      SCAN: begin
        if (last)
          state_n = DRAIN;
      end
      DRAIN: state_n = DONE;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      ox       <= '0;
      oy       <= '0;
      xc       <= '0;
      yc       <= '0;
      ev_valid <= 1'b0;
      ev_in    <= 1'b0;
      hit      <= 1'b0;
      hit_colour <= BG;
      oob      <= 1'b0;
    end else begin
      state    <= state_n;
      ev_valid <= (state == SCAN);
      ev_in    <= in_rng;

      if (state == IDLE && req) begin
        ox  <= req_x;
        oy  <= req_y;
        xc  <= '0;
        yc  <= '0;
        hit <= 1'b0;
        oob <= 1'b0;
        hit_colour <= BG;
      end

      if (state == SCAN) begin
        if (xc == XLAST) begin
          xc <= '0;
          yc <= yc + 7'd1;
        end else begin
          xc <= xc + 8'd1;
        end
      end

      // hit_colour still BG means no occupied pixel seen yet
      if (ev_valid) begin
        if (!ev_in) begin
          oob <= 1'b1;
          hit <= 1'b1;
        end else if (rd_data != BG) begin
          hit <= 1'b1;
          if (hit_colour == BG)
            hit_colour <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_box_probe.sv
// Randomised and directed bench for snake_box_probe against a
// pixel-array reference model of the box scan.
module tb_snake_box_probe;

  import snake_pkg::*;

  localparam int N = XDIM * YDIM;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       req;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic       busy;
  logic       done;
  logic       hit;
  logic [2:0] hit_colour;
  logic       oob;

  always #5 CLOCK_50 = ~CLOCK_50;

  snake_box_probe dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_colour (hit_colour),
    .oob        (oob)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [2:0] fb [YSCREEN][XSCREEN];

  int         m_phase;
  int         m_ox, m_oy;
  bit         m_hit, m_oob, m_found;
  logic [2:0] m_col;
  int         n_done;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic clr_model();
    m_hit   = 0;
    m_oob   = 0;
    m_found = 0;
    m_col   = BG;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic cycle(
    input bit       pl,
    input int       px,
    input int       py,
    input logic [2:0] pc,
    input bit       rq,
    input int       rx,
    input int       ry
  );
    int nxt, idx, c, r, wx, wy;
    plot   = pl;
    x      = px[7:0];
    y      = py[6:0];
    colour = pc;
    req    = rq;
    req_x  = rx[7:0];
    req_y  = ry[6:0];
    nxt    = m_phase;
    if (m_phase == 0) begin
      if (rq) begin
        m_ox = rx & 255;
        m_oy = ry & 127;
        clr_model();
        nxt = 1;
      end
    end else if (m_phase <= N) begin
      idx = m_phase - 1;
      c = m_ox + idx % XDIM;
      r = m_oy + idx / XDIM;
      if (c >= XSCREEN || r >= YSCREEN) begin
        m_oob = 1;
        m_hit = 1;
      end else if (fb[r][c] != BG) begin
        m_hit = 1;
        if (!m_found) begin
          m_found = 1;
          m_col = fb[r][c];
        end
      end
      nxt = m_phase + 1;
    end else if (m_phase == N + 1) begin
      nxt = N + 2;
    end else begin
      nxt = 0;
    end
    wx = px & 255;
    wy = py & 127;
    if (pl && wx < XSCREEN && wy < YSCREEN)
      fb[wy][wx] = pc;
    @(posedge CLOCK_50);
    #1;
    m_phase = nxt;
    if (done) n_done++;
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_phase == N + 2);
    if (m_phase == 0 || m_phase == N + 2) begin
      chk("hit", hit, m_hit);
      chk("hit_colour", hit_colour, m_col);
      chk("oob", oob, m_oob);
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 3'b000, 0, 0, 0);
  endtask

  task automatic put(input int px, input int py, input logic [2:0] pc);
    cycle(1, px, py, pc, 0, 0, 0);
  endtask

  // Probe from idle; optional plot at scan cycle wph, stray req at rph
  task automatic probe_x(
    input int rx, input int ry,
    input int wph, input int wx, input int wy, input logic [2:0] wc,
    input int rph
  );
    int k, lat;
    n_done = 0;
    cycle(0, 0, 0, 3'b000, 1, rx, ry);
    k = 1;
    lat = 0;
    while (m_phase != 0 && k < 300) begin
      cycle(k == wph, wx, wy, wc, k == rph, 3, 3);
      k++;
      if (done && lat == 0) lat = k;
    end
    chk("timeout", m_phase, 0);
    chk("latency", lat, N + 2);
    chk("one_done", n_done, 1);
  endtask

  task automatic probe(input int rx, input int ry);
    probe_x(rx, ry, -1, 0, 0, 3'b000, -1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    plot  = 1'b0;
    req   = 1'b0;
    @(posedge CLOCK_50);
    #1;
    reset   = 1'b0;
    m_phase = 0;
    clr_model();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_colour", hit_colour, BG);
    chk("rst_oob", oob, 0);
  endtask

  initial begin
    int rx, ry;
    for (int r = 0; r < YSCREEN; r++)
      for (int c = 0; c < XSCREEN; c++)
        fb[r][c] = BG;
    reset = 1'b1;
    plot = 0; x = 0; y = 0; colour = 0;
    req = 0; req_x = 0; req_y = 0;
    m_phase = 0;
    clr_model();
    repeat (2) @(posedge CLOCK_50);
    do_reset();

    probe(80, 60);
    chk("empty_hit", hit, 0);
    chk("empty_oob", oob, 0);
    chk("empty_col", hit_colour, 3'b000);

    put(85, 65, 3'b100);
    probe(80, 60);
    chk("single_hit", hit, 1);
    chk("single_col", hit_colour, 3'b100);
    probe(90, 60);
    chk("miss_hit", hit, 0);

    put(89, 60, 3'b010);
    put(80, 61, 3'b001);
    probe(80, 60);
    chk("raster_col", hit_colour, 3'b010);

    probe(155, 115);
    chk("edge_oob", oob, 1);
    chk("edge_hit", hit, 1);
    probe(150, 110);
    chk("corner_oob", oob, 0);
    probe(255, 127);
    chk("nowrap_oob", oob, 1);

    probe_x(0, 0, 50, 5, 9, 3'b111, -1);
    chk("early_wr_hit", hit, 1);
    put(5, 9, 3'b000);
    probe_x(0, 0, 96, 5, 9, 3'b111, 30);
    chk("same_cyc_hit", hit, 0);

    cycle(0, 0, 0, 3'b000, 1, 80, 60);
    repeat (49) idle();
    do_reset();
    idle();
    chk("post_rst_done", done, 0);
    probe(80, 60);
    chk("survive_hit", hit, 1);

    for (int i = 0; i < 4000; i++) begin
      rx = ($urandom % 4 == 0) ? $urandom % 256
                               : $urandom_range(0, 160);
      ry = ($urandom % 4 == 0) ? $urandom % 128
                               : $urandom_range(0, 120);
      cycle($urandom % 3 == 0,
            $urandom_range(0, 175), $urandom_range(0, 127),
            3'($urandom % 8),
            $urandom % 6 == 0, rx, ry);
    end
    while (m_phase != 0) idle();
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_box_probe.md
# snake_box_probe

Read-side counterpart to the pixel plot path. Snoops every plot write (x, y, colour) going to the VGA adapter into a private 160x120x3 shadow framebuffer. On request, scans an XDIM x YDIM box at a given origin and reports whether any pixel in it differs from the background colour. Snake control logic uses it for head/body/apple collision checks before committing a move.

## Interface
Parameters:
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- XDIM, 10, probe box width
- YDIM, 10, probe box height
- BG, 3'b000, background colour; any other colour counts as occupied

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- plot  in  1  write strobe, same signal driven to the VGA adapter
- x  in  8  write column
- y  in  7  write row
- colour  in  3  write colour
- req  in  1  probe request, sampled only when busy=0
- req_x  in  8  box origin column (top-left)
- req_y  in  7  box origin row
- busy  out  1  probe in progress
- done  out  1  one-cycle pulse: result valid
- hit  out  1  box contains a non-BG pixel or leaves the screen
- hit_colour  out  3  colour of first non-BG pixel in raster order; BG if none
- oob  out  1  some box pixel lies outside the screen

One clock; reset is synchronous and active-high (ports CLOCK_50 and reset).

## Operation
- Write port: when plot=1 and x<XSCREEN and y<YSCREEN, store colour at address y*160+x (15 bits, computed as (y<<7)+(y<<5)+x). Otherwise ignore. Writes accepted in every state, including during a scan.
- RAM is initialised to BG at configuration. reset does not clear it.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: busy=0. req=1 latches req_x/req_y, clears hit/hit_colour/oob, zeroes scan counters XC/YC, goes to SCAN.
- SCAN: busy=1. Issues one read per cycle at (req_x+XC, req_y+YC) in raster order: XC increments to XDIM-1, then wraps to 0 and YC increments. After issuing (XDIM-1, YDIM-1), goes to DRAIN.
- DRAIN: busy=1. Evaluates the last read, then goes to DONE.
- DONE: busy=1, done=1 for one cycle, then returns to IDLE.
- Evaluation, one cycle after issue, using a pipelined valid bit and in-range flag:
  - Out-of-screen pixel (sum computed 9/8 bits wide, no wrap; column>=XSCREEN or row>=YSCREEN): sets oob and hit. The read result is ignored.
  - In-range pixel with colour≠BG: sets hit. Also loads hit_colour if this is the first such pixel.
- hit, hit_colour and oob hold from DONE until the next accepted req.
- req while busy=1 is ignored and not queued.

## Timing
- Reset values: busy=0, done=0, hit=0, hit_colour=BG, oob=0, state=IDLE.
- Reset mid-scan: next cycle is IDLE with all outputs at reset values, and no done pulse.
- RAM read is synchronous: data is available the cycle after the address is issued.
- Write and read to the same address in the same cycle return the old data (read-before-write).
- N=XDIM*YDIM. With req sampled in cycle t:
  - SCAN occupies t+1..t+N.
  - DRAIN is t+N+1.
  - done=1 in t+N+2.
  - busy falls at t+N+3.
  - Default latency is 102 cycles.
- Back-to-back: earliest next req is accepted in t+N+3.
- A write in cycle c is visible to reads issued in c+1 or later.

## Structure
- Shared package snake_pkg holds:
  - XSCREEN, YSCREEN, XDIM, YDIM, BG
  - coordinate widths (8/7) and colour width (3)
  - the pixel-address function
- Sub-module shadow_fb: simple dual-port RAM, 19200x3, one write port, one synchronous read port, read-before-write, BG-initialised. Must infer block RAM.
- The FSM, counters and compare pipeline live in snake_box_probe.

## Test plan
- Empty screen: after reset, req at (80,60). Required: done at t+102, hit=0, oob=0, hit_colour=000.
- Single pixel: plot (85,65) colour 100, then req (80,60). Required: hit=1, hit_colour=100. Then req (90,60): hit=0.
- First in raster order: plot (89,60)=010 and (80,61)=001, then req (80,60). Required: hit_colour=010.
- Edge: req (155,115). Required: oob=1, hit=1. Req (150,110): oob=0. Req (255,127): oob=1 with no wrap to column 0.
- Concurrency: during a scan of (0,0), plot (5,9)=111 before that pixel is read. Required: hit=1. Plot at the same address in the same cycle the read issues: hit=0. Pulse req while busy: ignored, exactly one done.
- Reset at t+50 of a scan. Required: busy=0 and no done next cycle. A previously plotted pixel is still detected by a new req.
